// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-oriented UART transmitter between two
// frame requesters. A frame is granted whole (round-robin at frame
// boundaries). Its bytes are fed to the UART core one at a time, with a
// fixed idle gap after every byte. A stalled byte aborts the frame with err.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0,
  input  logic       req1,
  input  logic [9:0] len0,
  input  logic [9:0] len1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [9:0] idx,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic       busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       tx_rdy
);

  // Counter widths hold the full parameter value, so a count never wraps.
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t          state_r;
  logic [9:0]      len_r;
  logic [GW-1:0]   gap_cnt_r;
  logic [TW-1:0]   wait_cnt_r;
  logic            last1_r;    // 1 when requester 1 was the last one served
  logic            abort_r;    // current frame ended by timeout
  logic            rdy_q_r;    // previous-cycle copy of tx_rdy

  logic            win1_s;
  logic [9:0]      win_len_s;
  logic [7:0]      gnt_data_s;
  logic            rdy_rise_s;
  logic            last_byte_s;

  // Winner selection, byte source mux and completion-edge detect.
  always_comb begin
    win1_s      = 1'b0;
    win_len_s   = 10'd0;
    gnt_data_s  = 8'd0;
    rdy_rise_s  = 1'b0;
    last_byte_s = 1'b0;
    // Requester 1 wins when alone, or on a tie when 0 was served last.
    if (req1 && (!req0 || !last1_r)) begin
      win1_s = 1'b1;
    end else begin
      win1_s = 1'b0;
    end
    if (win1_s) begin
      win_len_s = len1;
    end else begin
      win_len_s = len0;
    end
    if (gnt1) begin
      gnt_data_s = data1;
    end else begin
      gnt_data_s = data0;
    end
    rdy_rise_s  = tx_rdy & ~rdy_q_r;
    last_byte_s = ((idx + 10'd1) == len_r);
  end

  // Registered copy of tx_rdy, used only to find its rising edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_q_r <= 1'b1;
    end else begin
      rdy_q_r <= tx_rdy;
    end
  end

  // Frame sequencer: grant, issue bytes, wait for completion, gap, finish.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      idx        <= 10'd0;
      len_r      <= 10'd0;
      gap_cnt_r  <= '0;
      wait_cnt_r <= '0;
      last1_r    <= 1'b1;
      abort_r    <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      tx_en      <= 1'b0;
      tx_data    <= 8'd0;
    end else begin
      // Pulse outputs are low unless a state below raises them.
      tx_en <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req0 || req1) begin
            gnt0    <= ~win1_s;
            gnt1    <= win1_s;
            len_r   <= win_len_s;
            idx     <= 10'd0;
            abort_r <= 1'b0;
            busy    <= 1'b1;
            // An empty frame skips straight to the finish handshake.
            if (win_len_s == 10'd0) begin
              state_r <= FIN;
            end else begin
              state_r <= ISSUE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          if (tx_rdy) begin
            tx_en      <= 1'b1;
            tx_data    <= gnt_data_s;
            wait_cnt_r <= '0;
            state_r    <= WAIT;
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT: begin
          if (rdy_rise_s) begin
            gap_cnt_r <= '0;
            state_r   <= GAP;
          end else if (wait_cnt_r == WAIT_LAST) begin
            // Byte never completed: drop the rest of the frame.
            wait_cnt_r <= wait_cnt_r + 1'b1;
            err        <= 1'b1;
            abort_r    <= 1'b1;
            state_r    <= FIN;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            if (last_byte_s) begin
              state_r <= FIN;
            end else begin
              idx     <= idx + 10'd1;
              state_r <= ISSUE;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + 1'b1;
          end
        end
        FIN: begin
          done0   <= gnt0 & ~abort_r;
          done1   <= gnt1 & ~abort_r;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          last1_r <= gnt1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a simple UART core model plus a scoreboard of
// expected byte issues and frame-end events, with direct timing checks.
module tb_uart_tx_arbiter;

  localparam int GAP       = 8;
  localparam int TMO       = 120;
  localparam int CORE_BUSY = 50;

  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic       who;
    logic [9:0] idx;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req0, req1;
  logic [9:0] len0, len1;
  logic [7:0] data0, data1;
  logic [9:0] idx;
  logic       gnt0, gnt1, done0, done1, err, busy, tx_en;
  logic [7:0] tx_data;
  logic       tx_rdy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   tx_count = 0;
  int   last_tx  = -1;
  int   busy_left = 0;
  logic force_low = 1'b0;
  logic hang      = 1'b0;
  exp_t sb[$];

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .idx(idx),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err(err), .busy(busy), .tx_en(tx_en), .tx_data(tx_data), .tx_rdy(tx_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester byte stores: a fixed pattern per requester.
  assign data0 = idx[7:0] ^ 8'hA5;
  assign data1 = idx[7:0] + 8'h3C;
  assign tx_rdy = !force_low && (busy_left == 0);

  function automatic logic [7:0] byte_of(input logic who, input logic [9:0] i);
    logic [7:0] lo;
    lo = i[7:0];
    if (who) return lo + 8'h3C;
    else return lo ^ 8'hA5;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic push_byte(input logic who, input int i);
    exp_t e;
    e.kind = K_BYTE; e.who = who; e.idx = 10'(i); e.data = byte_of(who, 10'(i));
    sb.push_back(e);
  endtask

  task automatic push_end(input logic who, input logic [1:0] kind);
    exp_t e;
    e.kind = kind; e.who = who; e.idx = 10'd0; e.data = 8'd0;
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic who, input int n);
    for (int i = 0; i < n; i++) push_byte(who, i);
    push_end(who, K_DONE);
  endtask

  task automatic wait_frames(input int n, input int max_cyc);
    int seen = 0;
    int k = 0;
    while (seen < n && k < max_cyc) begin
      @(negedge clk);
      k++;
      if (done0 || done1 || err) seen++;
    end
    if (seen < n) check_val("frame_timeout", seen, n);
  endtask

  // UART core model: goes busy CORE_BUSY cycles after each tx_en.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_en) busy_left = CORE_BUSY;
      else if (busy_left > 0 && !hang) busy_left = busy_left - 1;
    end
  end

  // Scoreboard monitor: every tx_en and every frame-end pulse pops one entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        last_tx = -1;
      end else begin
        if (tx_en) begin
          tx_count++;
          if (last_tx >= 0) check_val("tx_spacing", cyc - last_tx, CORE_BUSY + GAP + 2);
          last_tx = cyc;
          if (sb.size() == 0) begin
            check_val("sb_extra_tx", 1, 0);
          end else begin
            e = sb.pop_front();
            check_val("tx_kind", K_BYTE, e.kind);
            check_val("tx_gnt", {gnt1, gnt0}, e.who ? 2'b10 : 2'b01);
            check_val("tx_idx", idx, e.idx);
            check_val("tx_data", tx_data, e.data);
          end
        end
        if (done0 || done1 || err) begin
          last_tx = -1;
          if (sb.size() == 0) begin
            check_val("sb_extra_end", {err, done1, done0}, 0);
          end else begin
            e = sb.pop_front();
            check_val("end_kind", err ? K_ERR : K_DONE, e.kind);
            check_val("end_who", {err, done1, done0},
                      (e.kind == K_ERR) ? 3'b100 : (e.who ? 3'b010 : 3'b001));
          end
        end
      end
    end
  end

  initial begin
    int tc;
    int c0;
    int c1;
    int k;
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; len0 = 10'd0; len1 = 10'd0;
    repeat (3) @(negedge clk);
    check_val("rst_outs", {idx, gnt1, gnt0, done1, done0, err, busy, tx_en, tx_data}, 0);
    rstn = 1'b1;
    @(negedge clk);
    check_val("idle_busy", busy, 0);

    // Tie after reset: 0 first, then alternating 0,1,0,1.
    push_frame(1'b0, 2); push_frame(1'b1, 2); push_frame(1'b0, 2); push_frame(1'b1, 2);
    req0 = 1'b1; req1 = 1'b1; len0 = 10'd2; len1 = 10'd2;
    @(negedge clk);
    check_val("rr_first", {gnt1, gnt0}, 2'b01);
    check_val("rr_busy", busy, 1);
    wait_frames(4, 3000);
    req0 = 1'b0; req1 = 1'b0;

    // Three-byte frame from requester 0.
    push_frame(1'b0, 3);
    tc = tx_count;
    req0 = 1'b1; len0 = 10'd3;
    wait_frames(1, 1000);
    req0 = 1'b0;
    check_val("f3_txcount", tx_count - tc, 3);

    // Zero-length frame: done two cycles after the request, no byte.
    push_end(1'b1, K_DONE);
    tc = tx_count;
    req1 = 1'b1; len1 = 10'd0;
    @(negedge clk);
    check_val("zl_gnt", {gnt1, done1}, 2'b10);
    @(negedge clk);
    check_val("zl_done", done1, 1);
    req1 = 1'b0;
    @(negedge clk);
    check_val("zl_notx", tx_count - tc, 0);

    // Core busy at grant: hold off until tx_rdy returns; req drop is ignored.
    force_low = 1'b1;
    push_frame(1'b0, 1);
    tc = tx_count;
    req0 = 1'b1; len0 = 10'd1;
    repeat (10) @(negedge clk);
    check_val("blk_gnt", gnt0, 1);
    check_val("blk_notx", tx_count - tc, 0);
    req0 = 1'b0;
    force_low = 1'b0;
    @(negedge clk);
    check_val("blk_txen", tx_en, 1);
    wait_frames(1, 500);

    // Timeout: core never completes the first byte of a 5-byte frame.
    hang = 1'b1;
    push_byte(1'b0, 0);
    push_end(1'b0, K_ERR);
    req0 = 1'b1; len0 = 10'd5;
    k = 0;
    while (!tx_en && k < 100) begin @(negedge clk); k++; end
    check_val("to_txen_seen", tx_en, 1);
    c0 = cyc;
    req0 = 1'b0;
    k = 0;
    while (!err && k < TMO + 50) begin @(negedge clk); k++; end
    c1 = cyc;
    check_val("to_err_seen", err, 1);
    check_val("to_latency", c1 - c0, TMO);
    check_val("to_nodone", {done1, done0}, 0);
    @(negedge clk);
    check_val("to_busy", {busy, done0}, 0);
    hang = 1'b0;
    repeat (CORE_BUSY + 5) @(negedge clk);

    // Reset during byte 2 of a 4-byte frame; the held request restarts it.
    push_byte(1'b0, 0);
    push_byte(1'b0, 1);
    req0 = 1'b1; len0 = 10'd4;
    k = 0;
    while (!(tx_en && idx == 10'd1) && k < 1000) begin @(negedge clk); k++; end
    check_val("mr_byte2_seen", {tx_en, idx}, {1'b1, 10'd1});
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_val("mr_rst_now", {idx, gnt1, gnt0, done1, done0, err, busy, tx_en, tx_data}, 0);
    @(negedge clk);
    check_val("mr_rst_hold", {idx, gnt1, gnt0, done1, done0, err, busy, tx_en, tx_data}, 0);
    check_val("mr_sb_empty", sb.size(), 0);
    push_frame(1'b0, 4);
    rstn = 1'b1;
    @(negedge clk);
    check_val("mr_regnt", {gnt1, gnt0, idx}, {2'b01, 10'd0});
    wait_frames(1, 3000);
    req0 = 1'b0;

    repeat (5) @(negedge clk);
    check_val("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
